// File: rtl/prbs_pkg.sv
// Shared types and rate arithmetic for the PRBS transmit path.
// Used by the sequencer and by the generator itself.
package prbs_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    RUN,
    GAP,
    FIN
  } state_t;

  localparam logic [1:0] PRBS7  = 2'b00;
  localparam logic [1:0] PRBS9  = 2'b01;
  localparam logic [1:0] PRBS15 = 2'b10;
  localparam logic [1:0] PRBS31 = 2'b11;

  // NCO modulus: clock cycles in one 10 ms window.
  function automatic int unsigned nco_mod(
    input int unsigned clk_hz
  );
    return clk_hz / 100;
  endfunction

  function automatic logic [2:0] rate_norm(
    input logic [2:0] code
  );
    return (code > 3'd5) ? 3'd0 : code;
  endfunction

  // Bits transmitted per 10 ms at each rate code.
  function automatic logic [31:0] bits_10ms(
    input logic [2:0] code
  );
    logic [31:0] b;
    b = 32'd20000;
    case (rate_norm(code))
      3'd0:    b = 32'd20000;
      3'd1:    b = 32'd40000;
      3'd2:    b = 32'd80000;
      3'd3:    b = 32'd160000;
      3'd4:    b = 32'd320000;
      3'd5:    b = 32'd650000;
      default: b = 32'd20000;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/prbs_seq_ctrl_nco.sv
// Fractional bit-rate NCO: exactly inc ticks per MOD enabled cycles.
// The tick is registered; one step per enabled edge.
module prbs_tick_nco #(
  parameter int unsigned MOD = 1_300_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        enable,
  input  logic [31:0] inc,
  output logic        tick
);

  localparam logic [31:0] MOD_W = 32'(MOD);

  logic [31:0] acc;
  logic [31:0] sum;

  // acc < MOD and inc < MOD, so the sum never wraps 32 bits.
  assign sum = acc + inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      tick <= 1'b0;
    end else if (clear) begin
      acc  <= '0;
      tick <= 1'b0;
    end else if (enable) begin
      if (sum >= MOD_W) begin
        acc  <= sum - MOD_W;
        tick <= 1'b1;
      end else begin
        acc  <= sum;
        tick <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/prbs_seq_ctrl.sv
// Run sequencer for the PRBS generator: start, bit ticks,
// repeat/sweep bookkeeping, watchdog and abort.
module prbs_seq_ctrl
  import prbs_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 130_000_000,
  parameter int unsigned GAP_CYC     = 16,
  parameter int unsigned TIMEOUT_CYC =
    nco_mod(CLK_FREQ_HZ) + nco_mod(CLK_FREQ_HZ) / 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_start,
  input  logic       cmd_abort,
  input  logic [2:0] cfg_rate_sel,
  input  logic [1:0] cfg_prbs_sel,
  input  logic       cfg_sweep,
  input  logic [7:0] cfg_repeat,
  input  logic       gen_done,
  output logic       gen_start,
  output logic       gen_bit_tick,
  output logic [2:0] gen_rate_sel,
  output logic [1:0] gen_prbs_sel,
  output logic       busy,
  output logic       run_done,
  output logic       seq_done,
  output logic       err_timeout,
  output logic [9:0] run_idx
);

  localparam int unsigned MOD      = nco_mod(CLK_FREQ_HZ);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYC);
  localparam logic [31:0] WD_LAST  = 32'(TIMEOUT_CYC - 1);

  state_t      state;
  state_t      state_nx;
  logic [7:0]  rep_cfg;
  logic        sweep_cfg;
  logic [7:0]  rep_cnt;
  logic [1:0]  ord_cnt;
  logic [31:0] wd;
  logic [15:0] gap_cnt;
  logic [31:0] inc;

  logic accept;
  logic run_end;
  logic timeout;
  logic rep_step;
  logic ord_step;
  logic nco_clear;
  logic nco_en;

  assign inc       = bits_10ms(gen_rate_sel);
  assign nco_clear = (state_nx == ARM);
  assign nco_en    = (state_nx == RUN);

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    run_end  = 1'b0;
    timeout  = 1'b0;
    rep_step = 1'b0;
    ord_step = 1'b0;
    unique case (state)
      IDLE: begin
        if (cmd_start && !cmd_abort) begin
          accept   = 1'b1;
          state_nx = ARM;
        end
      end
      ARM: state_nx = RUN;
      RUN: begin
        if (gen_done) begin
          run_end  = 1'b1;
          state_nx = GAP;
        end else if (wd == WD_LAST) begin
          timeout  = 1'b1;
          state_nx = IDLE;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          if (rep_cnt < rep_cfg) begin
            rep_step = 1'b1;
            state_nx = ARM;
          end else if (sweep_cfg && ord_cnt != 2'd3) begin
            ord_step = 1'b1;
            state_nx = ARM;
          end else begin
            state_nx = FIN;
          end
        end
      end
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // Abort overrides every other event outside IDLE.
    if (cmd_abort && state != IDLE) begin
      state_nx = IDLE;
      run_end  = 1'b0;
      timeout  = 1'b0;
      rep_step = 1'b0;
      ord_step = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      gen_start    <= 1'b0;
      busy         <= 1'b0;
      run_done     <= 1'b0;
      seq_done     <= 1'b0;
      err_timeout  <= 1'b0;
      run_idx      <= '0;
      gen_rate_sel <= '0;
      gen_prbs_sel <= '0;
      rep_cfg      <= '0;
      sweep_cfg    <= 1'b0;
      rep_cnt      <= '0;
      ord_cnt      <= '0;
      wd           <= '0;
      gap_cnt      <= '0;
    end else begin
      state     <= state_nx;
      gen_start <= (state_nx == ARM);
      busy      <= (state_nx != IDLE);
      run_done  <= run_end;
      seq_done  <= (state_nx == FIN);
      if (accept) begin
        gen_rate_sel <= rate_norm(cfg_rate_sel);
        gen_prbs_sel <= cfg_prbs_sel;
        rep_cfg      <= cfg_repeat;
        sweep_cfg    <= cfg_sweep;
        rep_cnt      <= '0;
        ord_cnt      <= '0;
        run_idx      <= '0;
        err_timeout  <= 1'b0;
      end
      if (timeout)
        err_timeout <= 1'b1;
      if (run_end)
        run_idx <= run_idx + 10'd1;
      if (rep_step)
        rep_cnt <= rep_cnt + 8'd1;
      if (ord_step) begin
        rep_cnt      <= '0;
        ord_cnt      <= ord_cnt + 2'd1;
        gen_prbs_sel <= gen_prbs_sel + 2'd1;
      end
      // Watchdog holds cycles elapsed since gen_start.
      if (state_nx == ARM)
        wd <= '0;
      else if (state_nx == RUN)
        wd <= wd + 32'd1;
      if (state == GAP)
        gap_cnt <= gap_cnt + 16'd1;
      else
        gap_cnt <= '0;
    end
  end

  prbs_tick_nco #(
    .MOD(MOD)
  ) u_nco (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (nco_clear),
    .enable(nco_en),
    .inc   (inc),
    .tick  (gen_bit_tick)
  );

endmodule

// File: tb/tb_prbs_seq_ctrl.sv
// Bench for prbs_seq_ctrl: directed steps plus randomized sequences
// against an arithmetic tick model and a run-order model.
module tb_prbs_seq_ctrl;

  localparam int unsigned CLK_HZ = 130_000_000;
  localparam int unsigned GAP    = 5;
  localparam int unsigned TO     = 3000;
  localparam longint      MODL   = longint'(CLK_HZ / 100);

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_start = 1'b0;
  logic       cmd_abort = 1'b0;
  logic [2:0] cfg_rate_sel = '0;
  logic [1:0] cfg_prbs_sel = '0;
  logic       cfg_sweep = 1'b0;
  logic [7:0] cfg_repeat = '0;
  logic       gen_done = 1'b0;
  logic       gen_start;
  logic       gen_bit_tick;
  logic [2:0] gen_rate_sel;
  logic [1:0] gen_prbs_sel;
  logic       busy;
  logic       run_done;
  logic       seq_done;
  logic       err_timeout;
  logic [9:0] run_idx;

  int n_cmp = 0;
  int n_bad = 0;

  prbs_seq_ctrl #(
    .CLK_FREQ_HZ(CLK_HZ),
    .GAP_CYC    (GAP),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_start   (cmd_start),
    .cmd_abort   (cmd_abort),
    .cfg_rate_sel(cfg_rate_sel),
    .cfg_prbs_sel(cfg_prbs_sel),
    .cfg_sweep   (cfg_sweep),
    .cfg_repeat  (cfg_repeat),
    .gen_done    (gen_done),
    .gen_start   (gen_start),
    .gen_bit_tick(gen_bit_tick),
    .gen_rate_sel(gen_rate_sel),
    .gen_prbs_sel(gen_prbs_sel),
    .busy        (busy),
    .run_done    (run_done),
    .seq_done    (seq_done),
    .err_timeout (err_timeout),
    .run_idx     (run_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #900_000;
    $display("FAIL sim_time_limit: observed no end expected end");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Mbit/s * 10_000 = bits per 10 ms; codes 6/7 mean code 0.
  function automatic longint inc_of(input int r);
    int mbps[6] = '{2, 4, 8, 16, 32, 65};
    return longint'(mbps[(r > 5) ? 0 : r]) * 10000;
  endfunction

  // RUN cycle n (1-based) ticks when floor(n*inc/MOD) steps up.
  function automatic bit tick_exp(input longint n, input longint inc);
    return ((n * inc) / MODL) != (((n - 1) * inc) / MODL);
  endfunction

  task automatic do_start(input int r, input int p,
                          input bit sw, input int rep);
    cfg_rate_sel = 3'(r);
    cfg_prbs_sel = 2'(p);
    cfg_sweep    = sw;
    cfg_repeat   = 8'(rep);
    cmd_start    = 1'b1;
    step();
    cmd_start    = 1'b0;
  endtask

  // Entered in the gen_start cycle; leaves at done + GAP + 2.
  task automatic one_run(input int pe, input longint inc,
                         input int nt, input int idx);
    int n;
    int cnt;
    int err;
    chk("prbs_order", 32'(gen_prbs_sel), pe);
    n = 0;
    cnt = 0;
    err = 0;
    while (cnt < nt && n < nt * 70 + 10) begin
      step();
      n++;
      if (gen_bit_tick !== tick_exp(n, inc)) err++;
      if (gen_bit_tick === 1'b1) cnt++;
      if (run_done || seq_done || gen_start) err++;
    end
    chk("run_tick_model", err, 0);
    chk("run_tick_count", cnt, nt);
    gen_done = 1'b1;
    step();
    gen_done = 1'b0;
    chk("run_done_pulse", 32'(run_done), 1);
    chk("tick_after_done", 32'(gen_bit_tick), 0);
    chk("run_idx", 32'(run_idx), idx);
    err = 0;
    repeat (GAP) begin
      step();
      if (gen_start || seq_done || run_done || gen_bit_tick) err++;
    end
    chk("gap_quiet", err, 0);
    step();
  endtask

  task automatic seq(input int r, input int p, input bit sw,
                     input int rep, input int nt);
    longint inc;
    int runs;
    int pe;
    inc  = inc_of(r);
    runs = (sw ? 4 : 1) * (rep + 1);
    do_start(r, p, sw, rep);
    chk("start_pulse", 32'(gen_start), 1);
    chk("busy_rise", 32'(busy), 1);
    chk("rate_latch", 32'(gen_rate_sel), (r > 5) ? 0 : r);
    chk("idx_clear", 32'(run_idx), 0);
    chk("err_clear", 32'(err_timeout), 0);
    cfg_rate_sel = 3'($urandom);
    cfg_prbs_sel = 2'($urandom);
    cfg_sweep    = 1'($urandom);
    cfg_repeat   = 8'($urandom);
    for (int k = 0; k < runs; k++) begin
      pe = (p + k / (rep + 1)) % 4;
      if (k > 0) chk("next_start", 32'(gen_start), 1);
      one_run(pe, inc, nt, k + 1);
      if (k < runs - 1) begin
        chk("no_early_seq_done", 32'(seq_done), 0);
      end else begin
        chk("seq_done", 32'(seq_done), 1);
        chk("no_start_at_fin", 32'(gen_start), 0);
      end
    end
    step();
    chk("seq_done_single", 32'(seq_done), 0);
    chk("busy_fall", 32'(busy), 0);
    chk("final_run_idx", 32'(run_idx), runs);
  endtask

  task automatic tick_window(input int r, input int w0,
                             input int smin, input int smax);
    longint inc;
    int w;
    int cnt;
    int last;
    int mn;
    int mx;
    int err;
    inc = inc_of(r);
    w = w0;
    while (!tick_exp(longint'(w + 1), inc) && w < w0 + 100) w++;
    do_start(r, 0, 1'b0, 0);
    chk("win_start", 32'(gen_start), 1);
    cnt = 0;
    last = 0;
    mn = 1_000_000_000;
    mx = 0;
    err = 0;
    for (int n = 1; n <= w; n++) begin
      step();
      if (gen_bit_tick !== tick_exp(longint'(n), inc)) err++;
      if (gen_bit_tick === 1'b1) begin
        if (last > 0) begin
          if (n - last < mn) mn = n - last;
          if (n - last > mx) mx = n - last;
        end
        last = n;
        cnt++;
      end
      if (run_done || seq_done) err++;
    end
    chk("win_tick_model", err, 0);
    chk("win_tick_count", cnt, 32'((longint'(w) * inc) / MODL));
    chk("win_min_space", mn, smin);
    chk("win_max_space", mx, smax);
    cmd_abort = 1'b1;
    step();
    cmd_abort = 1'b0;
    chk("abort_tick_stop", 32'(gen_bit_tick), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_no_run_done", 32'(run_done), 0);
    err = 0;
    repeat (10) begin
      step();
      if (gen_bit_tick || run_done || seq_done || gen_start) err++;
    end
    chk("abort_quiet", err, 0);
  endtask

  initial begin
    int first;
    int err;
    repeat (2) step();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pulses",
        32'({gen_start, gen_bit_tick, run_done, seq_done}), 0);
    chk("rst_err", 32'(err_timeout), 0);
    chk("rst_idx", 32'(run_idx), 0);
    chk("rst_sel", 32'({gen_rate_sel, gen_prbs_sel}), 0);
    rst_n = 1'b1;
    step();

    // Single run at 65 Mbit/s, PRBS7.
    seq(5, 0, 1'b0, 0, 500);

    // Tick exactness at rate 0 and rate 3, ended by abort.
    tick_window(0, 2600, 65, 65);
    tick_window(3, 1900, 8, 9);

    // Sweep from order 10, two runs per order.
    seq(3, 2, 1'b1, 1, int'($urandom_range(4, 10)));

    // Watchdog timeout.
    do_start(5, 1, 1'b0, 0);
    chk("to_start", 32'(gen_start), 1);
    first = 0;
    err = 0;
    for (int k = 1; k <= int'(TO) + 5 && first == 0; k++) begin
      step();
      if (seq_done || run_done) err++;
      if (err_timeout === 1'b1) first = k;
    end
    chk("timeout_cycle", first, TO);
    chk("timeout_idle", 32'(busy), 0);
    chk("timeout_no_done", err, 0);
    step();
    chk("timeout_sticky", 32'(err_timeout), 1);
    cmd_abort = 1'b1;
    do_start(5, 0, 1'b0, 0);
    cmd_abort = 1'b0;
    chk("start_abort_ignored", 32'({gen_start, busy}), 0);
    chk("err_kept", 32'(err_timeout), 1);
    do_start(5, 0, 1'b0, 0);
    chk("err_cleared", 32'(err_timeout), 0);
    chk("restart_pulse", 32'(gen_start), 1);

    // Abort coinciding with gen_done.
    repeat ($urandom_range(3, 20)) step();
    gen_done  = 1'b1;
    cmd_abort = 1'b1;
    step();
    gen_done  = 1'b0;
    cmd_abort = 1'b0;
    chk("abort_done_no_run_done", 32'(run_done), 0);
    chk("abort_done_idle", 32'(busy), 0);
    chk("abort_done_tick", 32'(gen_bit_tick), 0);
    step();
    chk("abort_done_quiet",
        32'({run_done, seq_done, gen_start}), 0);

    // Randomized sequences.
    for (int i = 0; i < 4; i++) begin
      seq(int'($urandom_range(2, 7)), int'($urandom_range(0, 3)),
          1'($urandom), int'($urandom_range(0, 1)),
          int'($urandom_range(3, 12)));
      repeat ($urandom_range(0, 3)) step();
    end

    // Reset while in GAP.
    do_start(5, 1, 1'b0, 2);
    repeat (5) step();
    gen_done = 1'b1;
    step();
    gen_done = 1'b0;
    step();
    cmd_start = 1'b1;
    step();
    cmd_start = 1'b0;
    chk("start_ignored_busy", 32'(gen_start), 0);
    chk("gap_busy", 32'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs",
        32'({gen_start, gen_bit_tick, busy, run_done, seq_done,
             err_timeout, run_idx, gen_rate_sel, gen_prbs_sel}), 0);
    step();
    rst_n = 1'b1;
    err = 0;
    repeat (GAP + 4) begin
      step();
      if (gen_start || busy) err++;
    end
    chk("no_start_after_reset", err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/prbs_seq_ctrl.md
# prbs_seq_ctrl

Sequencer for the PRBS transmit generator. It latches a test configuration and issues the generator's `start` pulse. It produces the generator's `bit_tick` from `rate_sel` with an exact fractional NCO, then waits for `done`. It can repeat runs and optionally sweep all four PRBS orders, and it reports progress, completion and a watchdog timeout to the host register block.

## Interface
- `CLK_FREQ_HZ`, 130_000_000: system clock frequency. The NCO modulus is `MOD = CLK_FREQ_HZ/100`, i.e. one 10 ms window.
- `GAP_CYC`, 16: idle cycles between consecutive runs, minimum 1.
- `TIMEOUT_CYC`, `MOD + MOD/16`: cycles allowed from `gen_start` to `gen_done` before error.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_start` in 1: 1-clk pulse that begins a sequence. Ignored while `busy`.
- `cmd_abort` in 1: 1-clk pulse that stops the sequence at any time.
- `cfg_rate_sel` in 3: rate code 0..5 (2/4/8/16/32/65 Mbit/s). Codes 6 and 7 map to 0.
- `cfg_prbs_sel` in 2: PRBS order (00 = 7, 01 = 9, 10 = 15, 11 = 31). This is the start order when sweeping.
- `cfg_sweep` in 1: 1 steps `prbs_sel` through 00,01,10,11 starting at `cfg_prbs_sel` and wrapping to 00 after 11, running `cfg_repeat+1` runs per order.
- `cfg_repeat` in 8: runs per order minus 1.
- `gen_done` in 1: generator completion pulse.
- `gen_start` out 1: 1-clk start pulse to the generator.
- `gen_bit_tick` out 1: 1-clk bit strobe.
- `gen_rate_sel` out 3: registered rate code to the generator, held for the whole sequence.
- `gen_prbs_sel` out 2: registered PRBS order to the generator, held for the whole run.
- `busy` out 1: high in every state except IDLE.
- `run_done` out 1: 1-clk pulse per completed run.
- `seq_done` out 1: 1-clk pulse when the whole sequence completes normally.
- `err_timeout` out 1: sticky flag; cleared by the next accepted `cmd_start`.
- `run_idx` out 10: completed-run count within the sequence.

## Operation
- The FSM states are IDLE, ARM, RUN, GAP and FIN.
- **IDLE**:
  - On `cmd_start`, latch all `cfg_*` into `gen_rate_sel`/`gen_prbs_sel` and internal registers.
  - Clear `run_idx`, `err_timeout` and the repeat counter, then go to ARM.
- **ARM** (one cycle):
  - Assert `gen_start`.
  - Clear the NCO accumulator and the watchdog, then go to RUN.
- **RUN**:
  - The NCO adds `inc = bits_10ms(gen_rate_sel)` (20000/40000/80000/160000/320000/650000) each cycle.
  - When `acc + inc >= MOD`, assert `gen_bit_tick` and set `acc <= acc + inc - MOD`; otherwise set `acc <= acc + inc`.
  - The accumulator is 32 bits; `inc < MOD` is guaranteed because the largest `inc`, 650000, is at most MOD/2.
  - The watchdog counts cycles.
  - On `gen_done`: stop ticks, pulse `run_done`, increment `run_idx`, then go to GAP.
- **RUN watchdog**: if the watchdog reaches `TIMEOUT_CYC` without `gen_done`, set `err_timeout`, stop ticks and go to IDLE. `seq_done` is not asserted.
- **GAP**: count `GAP_CYC` cycles, then act on the repeat counter:
  - If the repeat counter is below `cfg_repeat`: increment it and go to ARM.
  - Else if `cfg_sweep` is set and fewer than 4 orders are done: clear the repeat counter, advance `gen_prbs_sel` (11 wraps to 00), and go to ARM.
  - Otherwise go to FIN.
- **FIN** (one cycle): pulse `seq_done`, then go to IDLE.
- **`cmd_abort`**:
  - From any state other than IDLE, go to IDLE on the next edge.
  - No `run_done` and no `seq_done`.
  - `gen_bit_tick` is low from the cycle after the abort is sampled.
  - The generator is left mid-run; the next `gen_start` restarts it.
- **Simultaneous events**:
  - `cmd_abort` wins over `gen_done` and over the timeout.
  - `cmd_start` together with `cmd_abort` in IDLE: start is ignored.
  - `gen_done` outside RUN is ignored.

## Timing
- Reset values: state IDLE, all pulses 0, `busy` 0, `err_timeout` 0, `run_idx` 0, `gen_rate_sel` 0, `gen_prbs_sel` 0, `acc` 0.
- All outputs are registered.
- `cmd_start` at cycle T:
  - `busy` rises at T+1.
  - `gen_start` is high at T+1.
  - First possible `gen_bit_tick` is at T+2.
- Tick count is exact: over any MOD consecutive RUN cycles starting from `acc = 0`, exactly `inc` ticks are issued.
- Tick spacing is `floor` or `ceil` of `MOD/inc`. At 130 MHz, rate 0 gives a constant 65-cycle spacing and rate 5 a constant 2-cycle spacing.
- `gen_done` sampled at cycle D:
  - `run_done` is high at D+1, with no tick at D+1.
  - The next `gen_start` is at D+1+GAP_CYC+1.
  - `seq_done` is one cycle after the final GAP ends.

## Structure
- Package `prbs_pkg`:
  - `bits_10ms` rate table function, shared with the generator.
  - FSM state enum.
  - PRBS order encodings.
  - `MOD` derivation.
- Sub-module `prbs_tick_nco`:
  - Ports: clear, enable, `inc`, tick.
  - Parameter: `MOD`.
- Controller FSM, counters and watchdog stay in `prbs_seq_ctrl`.

## Test plan
- **Single run, rate 5, PRBS7, repeat 0, no sweep, 130 MHz.** Required: `gen_start` 1 cycle after `cmd_start`; ticks every 2 cycles; model returns `gen_done` after 650000 ticks; `run_done` then `seq_done` after `GAP_CYC`+1; `run_idx` = 1.
- **Tick exactness, rate 0 and rate 3, gated RUN, no `gen_done`.** Required: rate 0 gives exactly 20000 ticks in 1_300_000 cycles; rate 3 gives 160000 ticks with spacings of only 8 or 9 cycles.
- **Sweep, `cfg_prbs_sel`=10, `cfg_repeat`=1, short model `done`.** Required: `gen_prbs_sel` sequence 10,10,11,11,00,00,01,01; 8 `run_done` pulses; `run_idx` = 8; one `seq_done`.
- **Timeout, model never asserts `done`.** Required: `err_timeout` set at `TIMEOUT_CYC` after `gen_start`; state IDLE; no `seq_done`; next `cmd_start` clears `err_timeout`.
- **Abort mid-RUN.** Required: ticks stop the cycle after the abort; `busy` falls; no `run_done`/`seq_done`; `cmd_abort` in the same cycle as `gen_done` yields no `run_done`.
- **`rst_n` low mid-GAP.** Required: all outputs immediately at reset values; a `cmd_start` ignored while `busy` produces no extra `gen_start`.
